// File: rtl/pll_cfg_pkg.sv
// Shared types, register map and frequency profile table for the PLL
// reconfiguration sequencer.
package pll_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      START,
      WAIT_LOCK,
      DONE,
      ERR
   } pll_state_e;

   localparam logic [5:0] ADDR_MODE  = 6'd0;
   localparam logic [5:0] ADDR_START = 6'd2;
   localparam logic [5:0] ADDR_N     = 6'd3;
   localparam logic [5:0] ADDR_M     = 6'd4;
   localparam logic [5:0] ADDR_C     = 6'd5;
   localparam logic [5:0] ADDR_K     = 6'd7;

   // MODE = 0 selects waitrequest handshaking on the reconfig bus.
   localparam logic [31:0] MODE_WAITREQ = 32'd0;
   localparam logic [31:0] START_GO     = 32'd1;

   localparam int NUM_WRITES = 7;

   typedef struct packed {
      logic [31:0] n;
      logic [31:0] m;
      logic [31:0] k;
      logic [31:0] c0;
      logic [31:0] c1;
      logic [31:0] c2;
   } pll_profile_t;

   // Counter word: [17] odd division, [16] bypass, [15:8] high count, [7:0] low count.
   // Odd divisors put the extra VCO cycle in the high phase.
   function automatic logic [31:0] cnt_word(input int unsigned div);
      logic [31:0] w;
      w = '0;
      if (div <= 1) begin
         w[16] = 1'b1;
      end else begin
         w[15:8] = 8'((div + 1) / 2);
         w[7:0]  = 8'(div / 2);
         w[17]   = (div % 2) != 0;
      end
      return w;
   endfunction

   // Output counters share one address; bits [22:18] pick which counter is written.
   function automatic logic [31:0] c_word(input logic [4:0] sel, input int unsigned div);
      logic [31:0] w;
      w = cnt_word(div);
      w[22:18] = sel;
      return w;
   endfunction

   // All profiles run from a 50 MHz reference with N bypassed and integer-only M (K = 0).
   // 0: VCO 1600 -> 160 / 160 / 27.118644 MHz
   // 1: VCO  800 -> 100 / 50 / 25 MHz
   // 2: VCO 1000 -> 125 / 125 / 62.5 MHz
   // 3: VCO  600 -> 150 / 75 / 50 MHz
   // 4: VCO  800 -> 200 / 100 / 50 MHz
   // 5: VCO  800 -> 133.33 / 66.67 / 33.33 MHz
   // 6: VCO 1200 -> 100 / 50 / 25 MHz
   // 7: VCO 1400 -> 100 / 50 / 25 MHz
   function automatic pll_profile_t profile_lookup(input logic [2:0] idx);
      pll_profile_t p;
      p.n = cnt_word(1);
      p.k = '0;
      case (idx)
         3'd0: begin p.m = cnt_word(32); p.c0 = c_word(5'd0, 10); p.c1 = c_word(5'd1, 10); p.c2 = c_word(5'd2, 59); end
         3'd1: begin p.m = cnt_word(16); p.c0 = c_word(5'd0, 8);  p.c1 = c_word(5'd1, 16); p.c2 = c_word(5'd2, 32); end
         3'd2: begin p.m = cnt_word(20); p.c0 = c_word(5'd0, 8);  p.c1 = c_word(5'd1, 8);  p.c2 = c_word(5'd2, 16); end
         3'd3: begin p.m = cnt_word(12); p.c0 = c_word(5'd0, 4);  p.c1 = c_word(5'd1, 8);  p.c2 = c_word(5'd2, 12); end
         3'd4: begin p.m = cnt_word(16); p.c0 = c_word(5'd0, 4);  p.c1 = c_word(5'd1, 8);  p.c2 = c_word(5'd2, 16); end
         3'd5: begin p.m = cnt_word(16); p.c0 = c_word(5'd0, 6);  p.c1 = c_word(5'd1, 12); p.c2 = c_word(5'd2, 24); end
         3'd6: begin p.m = cnt_word(24); p.c0 = c_word(5'd0, 12); p.c1 = c_word(5'd1, 24); p.c2 = c_word(5'd2, 48); end
         default: begin p.m = cnt_word(28); p.c0 = c_word(5'd0, 14); p.c1 = c_word(5'd1, 28); p.c2 = c_word(5'd2, 56); end
      endcase
      return p;
   endfunction

   // Fixed write order: MODE, N, M, K, C0, C1, C2.
   function automatic logic [5:0] write_addr(input logic [2:0] idx);
      case (idx)
         3'd0:    return ADDR_MODE;
         3'd1:    return ADDR_N;
         3'd2:    return ADDR_M;
         3'd3:    return ADDR_K;
         3'd4,
         3'd5,
         3'd6:    return ADDR_C;
         default: return ADDR_MODE;
      endcase
   endfunction

   function automatic logic [31:0] write_data(input pll_profile_t p, input logic [2:0] idx);
      case (idx)
         3'd0:    return MODE_WAITREQ;
         3'd1:    return p.n;
         3'd2:    return p.m;
         3'd3:    return p.k;
         3'd4:    return p.c0;
         3'd5:    return p.c1;
         3'd6:    return p.c2;
         default: return MODE_WAITREQ;
      endcase
   endfunction

endpackage

// File: rtl/pll_cfg_seq_lock_sync.sv
// Lock detector: 2-flop synchronizer on pll_locked plus a stability counter.
// The whole detector is held clear while the sequencer is not waiting for lock,
// so a lock indication left over from the previous configuration never counts
// toward the new one.
module pll_lock_sync
   import pll_cfg_pkg::*;
#(
   parameter int LOCK_STABLE = 16,
   parameter int CNT_W       = 20
) (
   input  logic mgmt_clk,
   input  logic mgmt_reset,
   input  logic clr,
   input  logic lock_async,
   output logic lock_stable
);

   localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(LOCK_STABLE - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;

   // Next-state for the synchronizer and the saturating run-length counter.
   always_comb begin
      sync1_d    = lock_async;
      sync2_d    = sync1_q;
      stab_cnt_d = stab_cnt_q;
      if (clr) begin
         sync1_d    = 1'b0;
         sync2_d    = 1'b0;
         stab_cnt_d = '0;
      end else if (!sync2_q) begin
         stab_cnt_d = '0;
      end else if (stab_cnt_q != STAB_MAX) begin
         stab_cnt_d = stab_cnt_q + CNT_W'(1);
      end
   end

   // Register update with synchronous reset.
   always_ff @(posedge mgmt_clk) begin
      if (mgmt_reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         stab_cnt_q <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         stab_cnt_q <= stab_cnt_d;
      end
   end

   // Counter holds the number of earlier consecutive high cycles, so this
   // fires in the LOCK_STABLE-th consecutive synchronized-high cycle.
   assign lock_stable = sync2_q && (stab_cnt_q == STAB_MAX);

endmodule

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: writes a profile to the reconfig block,
// starts the reconfiguration and waits for a stable lock or a timeout.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for cfg_req
// WRITE     | issuing write idx_q (MODE, N, M, K, C0, C1, C2)
// START     | issuing the START write
// WAIT_LOCK | waiting for stable lock, timeout counter running
// DONE      | one-cycle cfg_done pulse
// ERR       | one cycle after a bad request or lock timeout
module pll_cfg_seq
   import pll_cfg_pkg::*;
#(
   parameter int NUM_PROFILES = 4,
   parameter int LOCK_TIMEOUT = 1000000,
   parameter int LOCK_STABLE  = 16
) (
   input  logic        mgmt_clk,
   input  logic        mgmt_reset,
   input  logic        cfg_req,
   input  logic [2:0]  cfg_sel,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err,
   input  logic        pll_locked,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_write,
   output logic [31:0] mgmt_writedata,
   input  logic        mgmt_waitrequest
);

   localparam int               CNT_W      = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_MAX     = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [2:0]       LAST_IDX   = 3'(NUM_WRITES - 1);
   localparam logic [3:0]       NUM_PROF_L = 4'(NUM_PROFILES);

   pll_state_e       state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [2:0]       sel_q, sel_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] timer_q, timer_d;

   logic             sel_ok;
   logic             lock_stable;
   pll_profile_t     profile;

   assign sel_ok  = {1'b0, cfg_sel} < NUM_PROF_L;
   assign profile = profile_lookup(sel_q);

   pll_lock_sync #(
      .LOCK_STABLE (LOCK_STABLE),
      .CNT_W       (CNT_W)
   ) u_lock_sync (
      .mgmt_clk    (mgmt_clk),
      .mgmt_reset  (mgmt_reset),
      .clr         (state_q != WAIT_LOCK),
      .lock_async  (pll_locked),
      .lock_stable (lock_stable)
   );

   // Next-state, write index, latched profile, sticky error and lock timeout.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sel_d   = sel_q;
      err_d   = err_q;
      timer_d = '0;
      case (state_q)
         IDLE: begin
            if (cfg_req) begin
               if (sel_ok) begin
                  state_d = WRITE;
                  idx_d   = '0;
                  sel_d   = cfg_sel;
                  err_d   = 1'b0;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
         WRITE: begin
            if (!mgmt_waitrequest) begin
               if (idx_q == LAST_IDX) begin
                  state_d = START;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         START: begin
            if (!mgmt_waitrequest) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            timer_d = timer_q;
            // Lock is checked first so it wins over a coincident timeout.
            if (lock_stable) begin
               state_d = DONE;
            end else if (timer_q == TO_MAX) begin
               state_d = ERR;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus and status outputs decoded from registered state only, so address
   // and data stay stable while the bus stalls.
   always_comb begin
      mgmt_write     = 1'b0;
      mgmt_address   = '0;
      mgmt_writedata = '0;
      cfg_busy       = 1'b0;
      cfg_done       = 1'b0;
      case (state_q)
         WRITE: begin
            mgmt_write     = 1'b1;
            mgmt_address   = write_addr(idx_q);
            mgmt_writedata = write_data(profile, idx_q);
            cfg_busy       = 1'b1;
         end
         START: begin
            mgmt_write     = 1'b1;
            mgmt_address   = ADDR_START;
            mgmt_writedata = START_GO;
            cfg_busy       = 1'b1;
         end
         WAIT_LOCK: cfg_busy = 1'b1;
         DONE:      cfg_done = 1'b1;
         default:   ;
      endcase
   end

   assign cfg_err = err_q;

   // State registers with synchronous reset; reset abandons any sequence in flight.
   always_ff @(posedge mgmt_clk) begin
      if (mgmt_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sel_q   <= '0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
         timer_q <= timer_d;
      end
   end

endmodule
